rare_term_monitor: RTL and testbench

//  Parametrised, multi-channel successor of the registered product-term cells in the trojan-detection set.

---
 rtl/rtm_pkg.sv | 12 +
 rtl/rtm_channel.sv | 68 ++++++
 rtl/rare_term_monitor.sv | 60 ++++++
 tb/tb_rare_term_monitor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rtm_pkg.sv
// rtl/rtm_pkg.sv - shared constants and helpers for the rare-term monitor
package rtm_pkg;

   localparam logic MODE_CONSEC = 1'b0;
   localparam logic MODE_CUMUL  = 1'b1;

   // Counter width just wide enough to hold the alarm threshold
   function automatic int rtm_cnt_w(input int thresh);
      return $clog2(thresh + 1);
   endfunction

endpackage

// File: rtl/rtm_channel.sv
// rtl/rtm_channel.sv - one monitor channel: input pipeline, masked match, counter, alarm
module rtm_channel
   import rtm_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int STAGES = 1,
   parameter int THRESH = 4,
   parameter int CNT_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] match_val,
   input  logic [WIDTH-1:0] care_mask,
   input  logic             mode,
   input  logic             clr,
   output logic             hit,
   output logic [CNT_W-1:0] cnt,
   output logic             alarm
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   logic [WIDTH-1:0] pipe [STAGES];
   logic             m;
   logic [CNT_W-1:0] cnt_nxt;

   // Input delay line; the last stage feeds the comparator
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Masked compare and next count; an all-zero mask disables matching entirely
   always_comb begin
      m       = (|care_mask) && (((pipe[STAGES-1] ^ match_val) & care_mask) == '0);
      cnt_nxt = cnt;
      if (m) begin
         cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      end else if (mode == MODE_CONSEC) begin
         cnt_nxt = '0;
      end
   end

   // Hit, counter and sticky alarm share one edge so hit and cnt stay aligned; clr spares hit
   always_ff @(posedge clk) begin
      if (rst) begin
         hit   <= 1'b0;
         cnt   <= '0;
         alarm <= 1'b0;
      end else begin
         hit <= m;
         if (clr) begin
            cnt   <= '0;
            alarm <= 1'b0;
         end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt >= THRESH_C) alarm <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rare_term_monitor.sv
// rtl/rare_term_monitor.sv - multi-channel rare-event monitor top
module rare_term_monitor
   import rtm_pkg::*;
#(
   parameter  int WIDTH    = 3,
   parameter  int CHANNELS = 4,
   parameter  int STAGES   = 1,
   parameter  int THRESH   = 4,
   localparam int CNT_W    = rtm_cnt_w(THRESH)
) (
   input  logic                      mon_clk,
   input  logic                      mon_rst,
   input  logic [CHANNELS*WIDTH-1:0] in_vec,
   input  logic [WIDTH-1:0]          match_val,
   input  logic [WIDTH-1:0]          care_mask,
   input  logic                      mode,
   input  logic                      clr,
   output logic [CHANNELS-1:0]       hit,
   output logic [CHANNELS*CNT_W-1:0] cnt_flat,
   output logic [CHANNELS-1:0]       alarm,
   output logic                      alarm_any,
   output logic                      alarm_irq
);

   if (THRESH < 1) begin : g_bad_thresh
      $error("rare_term_monitor: THRESH must be at least 1");
   end

   logic [CHANNELS-1:0] alarm_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      rtm_channel #(
         .WIDTH  (WIDTH),
         .STAGES (STAGES),
         .THRESH (THRESH),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk       (mon_clk),
         .rst       (mon_rst),
         .din       (in_vec[c*WIDTH +: WIDTH]),
         .match_val (match_val),
         .care_mask (care_mask),
         .mode      (mode),
         .clr       (clr),
         .hit       (hit[c]),
         .cnt       (cnt_flat[c*CNT_W +: CNT_W]),
         .alarm     (alarm[c])
      );
   end

   // Delayed alarm copy so a newly set bit is visible for exactly one cycle
   always_ff @(posedge mon_clk) begin
      if (mon_rst) alarm_q <= '0;
      else         alarm_q <= alarm;
   end

   assign alarm_any = |alarm;
   assign alarm_irq = |(alarm & ~alarm_q);

endmodule

// File: tb/tb_rare_term_monitor.sv
// tb/tb_rare_term_monitor.sv - directed self-checking bench for rare_term_monitor
module tb_rare_term_monitor;

   localparam int W  = 3;
   localparam int CH = 4;
   localparam int CW = 3;

   logic            mon_clk = 1'b0;
   logic            mon_rst;
   logic [CH*W-1:0] in_vec;
   logic [W-1:0]    match_val;
   logic [W-1:0]    care_mask;
   logic            mode;
   logic            clr;
   logic [CH-1:0]   hit;
   logic [CH*CW-1:0] cnt_flat;
   logic [CH-1:0]   alarm;
   logic            alarm_any;
   logic            alarm_irq;

   int n_checks = 0;
   int n_pass   = 0;

   rare_term_monitor dut (
      .mon_clk   (mon_clk),
      .mon_rst   (mon_rst),
      .in_vec    (in_vec),
      .match_val (match_val),
      .care_mask (care_mask),
      .mode      (mode),
      .clr       (clr),
      .hit       (hit),
      .cnt_flat  (cnt_flat),
      .alarm     (alarm),
      .alarm_any (alarm_any),
      .alarm_irq (alarm_irq)
   );

   always #5 mon_clk = ~mon_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge mon_clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_of(input int c);
      return 32'(cnt_flat[c*CW +: CW]);
   endfunction

   task automatic set_ch(input int c, input logic [W-1:0] v);
      in_vec[c*W +: W] = v;
   endtask

   // ch2 cumulative pattern: match/miss/match/miss/match/match then six matches
   logic [11:0] pat2 = 12'b1111_1111_0101;
   logic [2:0]  exp2 [12] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};

   initial begin
      match_val = 3'b101;
      care_mask = 3'b111;
      mode      = 1'b0;
      clr       = 1'b0;
      in_vec    = '1;
      mon_rst   = 1'b1;

      // Reset with all-ones input
      tick();
      check("rst_hit",   32'(hit), 0);
      check("rst_cnt",   32'(cnt_flat), 0);
      check("rst_alarm", 32'(alarm), 0);
      check("rst_irq",   32'(alarm_irq), 0);
      mon_rst = 1'b0;
      in_vec  = '0;
      tick();
      tick();

      // Latency: one-cycle match on ch0
      set_ch(0, 3'b101);
      tick();
      check("lat_hit_early", 32'(hit[0]), 0);
      set_ch(0, 3'b000);
      tick();
      check("lat_hit", 32'(hit[0]), 1);
      check("lat_cnt", cnt_of(0), 1);
      tick();
      check("lat_hit_off", 32'(hit[0]), 0);
      check("lat_cnt_off", cnt_of(0), 0);

      // Consecutive on ch1
      for (int i = 0; i < 6; i++) begin
         set_ch(1, (i < 4) ? 3'b101 : 3'b000);
         tick();
         if (i >= 1 && i <= 3) check($sformatf("cons_cnt%0d", i), cnt_of(1), 32'(i));
         if (i == 3) check("cons_no_alarm", 32'(alarm[1]), 0);
         if (i == 4) begin
            check("cons_cnt4",  cnt_of(1), 4);
            check("cons_alarm", 32'(alarm[1]), 1);
            check("cons_irq",   32'(alarm_irq), 1);
            check("cons_any",   32'(alarm_any), 1);
         end
         if (i == 5) begin
            check("cons_cnt_reset", cnt_of(1), 0);
            check("cons_sticky",    32'(alarm[1]), 1);
            check("cons_irq_off",   32'(alarm_irq), 0);
         end
      end

      // Cumulative on ch2, with saturation
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_alarm", 32'(alarm), 0);
      mode = 1'b1;
      for (int i = 0; i < 13; i++) begin
         if (i < 12) set_ch(2, pat2[i] ? 3'b101 : 3'b000);
         else        set_ch(2, 3'b000);
         tick();
         if (i > 0) begin
            check($sformatf("cum_cnt%0d", i-1), cnt_of(2), 32'(exp2[i-1]));
            check($sformatf("cum_alarm%0d", i-1), 32'(alarm[2]), (i-1 >= 5) ? 1 : 0);
            if (i-1 == 5) check("cum_irq", 32'(alarm_irq), 1);
         end
      end
      tick();
      check("cum_hold", cnt_of(2), 7);

      // Clear colliding with a match on ch3
      mode = 1'b0;
      clr  = 1'b1;
      tick();
      clr  = 1'b0;
      set_ch(3, 3'b101);
      tick();
      tick();
      tick();
      tick();
      check("clr_pre_cnt", cnt_of(3), 3);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_cnt",   cnt_of(3), 0);
      check("clr_alarm3", 32'(alarm[3]), 0);
      check("clr_irq",   32'(alarm_irq), 0);
      check("clr_hit_kept", 32'(hit[3]), 1);
      tick();
      check("clr_next_cnt", cnt_of(3), 1);
      set_ch(3, 3'b000);
      tick();
      tick();

      // Masking
      care_mask = 3'b101;
      set_ch(0, 3'b111);
      tick();
      tick();
      check("mask_hit", 32'(hit[0]), 1);
      care_mask = 3'b000;
      tick();
      tick();
      check("mask_off_hit", 32'(hit), 0);
      check("mask_off_cnt", cnt_of(0), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
